// File: rtl/mem_line_requester.sv
// ---------------------------------------------------------------------------
// mem_line_requester
//   Initiator side of the 128-bit line memory interface. Takes one line read
//   or write per client handshake and issues it to the line memory. It follows
//   the memory's ready-based busy window, then captures the returned line.
//   It hands back a response with an error flag. A transaction that hangs is
//   aborted with a single reset_mem_req pulse.
//
// Ports
//   clk, reset                   clock, async active-high reset
//   req_valid/req_ready          client request handshake
//   req_we/req_addr/req_wdata    request payload (addr[1:0] forced to 0)
//   resp_valid/resp_ready        client response handshake
//   resp_rdata/resp_error        response payload (rdata 0 for writes/errors)
//   mem_requested/mem_we         memory 'requested' / 'we'
//   mem_addr/mem_wr_data         memory 'addr_in' / 'wr_data'
//   mem_reset_req                memory 'reset_mem_req' (abort pulse)
//   mem_rd_data/mem_ready        memory 'rd_data_out' / 'ready'
//   is_loading_memory_into_core  memory preload in progress, blocks new accepts
// ---------------------------------------------------------------------------
module mem_line_requester #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [127:0]      req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [127:0]      resp_rdata,
  output logic              resp_error,
  output logic              mem_requested,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [127:0]      mem_wr_data,
  output logic              mem_reset_req,
  input  logic [127:0]      mem_rd_data,
  input  logic              mem_ready,
  input  logic              is_loading_memory_into_core
);

  localparam int         DATA_W = 128;
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_ABORT,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [7:0]          r_tcnt;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic                w_accept;
  logic                w_timeout;

  assign w_timeout = (r_tcnt >= TO_LIM);

  always_comb begin
    w_next        = r_state;
    req_ready     = 1'b0;
    mem_requested = 1'b0;
    mem_reset_req = 1'b0;
    resp_valid    = 1'b0;
    w_accept      = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = !is_loading_memory_into_core;
        if (req_valid && !is_loading_memory_into_core) begin
          w_accept = 1'b1;
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Memory may still be busy from earlier activity; keep requesting.
        mem_requested = 1'b1;
        if (mem_ready)      w_next = S_WAIT;
        else if (w_timeout) w_next = S_ABORT;
      end
      S_WAIT: begin
        // Held high through the busy window so the memory keeps its write
        // muxing; dropped as soon as ready returns so it does not restart.
        mem_requested = !mem_ready;
        if (mem_ready)      w_next = S_CAPTURE;
        else if (w_timeout) w_next = S_ABORT;
      end
      S_CAPTURE: w_next = S_RESP;
      S_ABORT: begin
        mem_reset_req = 1'b1;
        w_next        = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign mem_we      = mem_requested & r_we;
  assign mem_addr    = r_addr;
  assign mem_wr_data = r_wdata;
  assign resp_rdata  = r_rdata;
  assign resp_error  = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_tcnt  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            r_wdata <= req_wdata;
            r_tcnt  <= '0;
          end
        end
        S_ISSUE, S_WAIT: begin
          if (r_tcnt != 8'hFF) r_tcnt <= r_tcnt + 8'd1;
        end
        S_CAPTURE: begin
          // Memory output register lags ready by one cycle; sample it here.
          r_rdata <= r_we ? '0 : mem_rd_data;
          r_err   <= 1'b0;
        end
        S_ABORT: begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_requester.sv
module tb_mem_line_requester;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_ready, req_we;
  logic [19:0]  req_addr;
  logic [127:0] req_wdata;
  logic         resp_valid, resp_ready, resp_error;
  logic [127:0] resp_rdata;
  logic         mem_requested, mem_we, mem_reset_req;
  logic [19:0]  mem_addr;
  logic [127:0] mem_wr_data;
  logic [127:0] mem_rd_data = '0;
  logic         mem_ready;
  logic         is_loading_memory_into_core;

  always #5 clk = ~clk;

  mem_line_requester #(.TIMEOUT_CYCLES(TO), .ADDR_W(20)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_requested(mem_requested), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_reset_req(mem_reset_req),
    .mem_rd_data(mem_rd_data), .mem_ready(mem_ready),
    .is_loading_memory_into_core(is_loading_memory_into_core)
  );

  // Line memory environment: busy for env_B cycles after accepting a request
  // (ready returns in the last one), read data appears one cycle after that.
  logic [127:0] env_mem [256];
  int           env_cnt  = 0;
  bit           env_pend = 1'b0;
  bit           env_we   = 1'b0;
  logic [7:0]   env_idx  = '0;
  int           env_B    = 5;
  bit           env_hang = 1'b0;
  int           rst_pulses = 0;
  bit           pre_we = 1'b0;
  logic [7:0]   pre_idx = '0;
  logic [127:0] pre_data = '0;

  assign mem_ready = (env_cnt == 0) && !(env_hang && env_pend);

  always @(posedge clk) begin
    if (pre_we) env_mem[pre_idx] <= pre_data;
    if (mem_reset_req) begin
      rst_pulses <= rst_pulses + 1;
      env_pend   <= 1'b0;
      env_cnt    <= 0;
    end else if (env_pend && env_cnt == 0 && !env_hang) begin
      if (!env_we) mem_rd_data <= env_mem[env_idx];
      env_pend <= 1'b0;
    end else if (env_cnt > 0) begin
      env_cnt <= env_cnt - 1;
    end else if (mem_requested && mem_ready) begin
      env_pend <= 1'b1;
      env_cnt  <= env_B - 1;
      env_we   <= mem_we;
      env_idx  <= mem_addr[9:2];
      if (mem_we) env_mem[mem_addr[9:2]] <= mem_wr_data;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] ref_mem [int];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One complete transaction with expected latency (cycles from the accept
  // cycle to the first resp_valid cycle), payload and response stall length.
  task automatic do_txn(input bit we, input logic [19:0] addr, input logic [127:0] wd,
                        input int B, input bit hang, input int rdelay,
                        input int exp_lat, input logic [127:0] exp_rd,
                        input bit exp_err, input string tag);
    int g;
    int n;
    logic [127:0] held;
    env_B    = B;
    env_hang = hang;
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk({tag, ":req_ready"}, 128'(req_ready), 128'(1));
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = rnd128();
    req_addr  = 20'($urandom());
    @(negedge clk);
    chk({tag, ":issue_req"}, 128'(mem_requested), 128'(1));
    chk({tag, ":issue_we"}, 128'(mem_we), 128'(we));
    chk({tag, ":mem_addr"}, 128'(mem_addr), 128'({addr[19:2], 2'b00}));
    if (we) chk({tag, ":mem_wr_data"}, mem_wr_data, wd);
    n = 1;
    while (!resp_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ":latency"}, 128'(n), 128'(exp_lat));
    chk({tag, ":resp_error"}, 128'(resp_error), 128'(exp_err));
    chk({tag, ":resp_rdata"}, resp_rdata, exp_rd);
    held = resp_rdata;
    for (int i = 0; i < rdelay; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      chk({tag, ":stall_valid"}, 128'(resp_valid), 128'(1));
      chk({tag, ":stall_rdata"}, resp_rdata, held);
      chk({tag, ":stall_req_ready"}, 128'(req_ready), 128'(0));
      chk({tag, ":stall_mem_req"}, 128'({mem_requested, mem_we}), 128'(0));
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk({tag, ":resp_done"}, 128'(resp_valid), 128'(0));
    chk({tag, ":idle_ready"}, 128'(req_ready), 128'(1));
  endtask

  initial begin
    logic [127:0] line_a;
    logic [127:0] wd;
    logic [19:0]  a;
    int           p0;
    int           idx;
    bit           we;
    int           B;

    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    is_loading_memory_into_core = 1'b0;

    line_a   = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
    pre_idx  = 8'h41;
    pre_data = line_a;
    pre_we   = 1'b1;
    ref_mem[32'h41] = line_a;
    @(posedge clk);
    #1 pre_we = 1'b0;
    @(negedge clk);
    chk("rst:req_ready", 128'(req_ready), 128'(1));
    chk("rst:outs", 128'({resp_valid, resp_error, mem_requested, mem_we, mem_reset_req}), 128'(0));
    chk("rst:mem_addr", 128'(mem_addr), 128'(0));
    chk("rst:resp_rdata", resp_rdata, 128'(0));
    reset = 1'b0;

    // Directed: preloaded line read, write then readback with stall, timeout.
    do_txn(1'b0, 20'h00104, '0, 5, 1'b0, 0, 8, line_a, 1'b0, "rd104");
    wd = {32'd4, 32'd3, 32'd2, 32'd1};
    do_txn(1'b1, 20'h00203, wd, 5, 1'b0, 0, 8, '0, 1'b0, "wr203");
    ref_mem[32'h80] = wd;
    do_txn(1'b0, 20'h00200, '0, 5, 1'b0, 10, 8, wd, 1'b0, "rd200");
    p0 = rst_pulses;
    do_txn(1'b0, 20'h00104, '0, 5, 1'b1, 0, TO + 3, '0, 1'b1, "timeout");
    chk("timeout:reset_pulses", 128'(rst_pulses - p0), 128'(1));
    env_hang = 1'b0;

    // Preload in progress blocks accepts until it drops.
    is_loading_memory_into_core = 1'b1;
    req_valid = 1'b1;
    req_addr  = 20'h00104;
    req_we    = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("loading:req_ready", 128'(req_ready), 128'(0));
      chk("loading:mem_req", 128'(mem_requested), 128'(0));
    end
    req_valid = 1'b0;
    is_loading_memory_into_core = 1'b0;
    do_txn(1'b0, 20'h00106, '0, 5, 1'b0, 0, 8, line_a, 1'b0, "after_load");

    // Reset while the memory is busy.
    env_B = 5;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 20'h00104;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst:in_wait", 128'(mem_requested), 128'(1));
    p0 = rst_pulses;
    #2 reset = 1'b1;
    #1;
    chk("async_rst:outs", 128'({resp_valid, resp_error, mem_requested, mem_we, mem_reset_req}), 128'(0));
    chk("async_rst:mem_addr", 128'(mem_addr), 128'(0));
    chk("async_rst:req_ready", 128'(req_ready), 128'(1));
    @(negedge clk);
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst:no_resp", 128'({resp_valid, mem_requested}), 128'(0));
    end
    chk("post_rst:req_ready", 128'(req_ready), 128'(1));
    chk("post_rst:no_pulse", 128'(rst_pulses - p0), 128'(0));

    // Randomized traffic over lines 0x10..0x17; every line is written first.
    for (int i = 0; i < 28; i++) begin
      idx = 16 + (i < 8 ? i : int'($urandom_range(0, 7)));
      we  = (i < 8) ? 1'b1 : 1'($urandom());
      a   = 20'((idx << 2) | int'($urandom_range(0, 3)));
      wd  = rnd128();
      B   = int'($urandom_range(1, 6));
      if (we) begin
        do_txn(1'b1, a, wd, B, 1'b0, int'($urandom_range(0, 3)), B + 3, '0, 1'b0, "rnd_wr");
        ref_mem[idx] = wd;
      end else begin
        do_txn(1'b0, a, '0, B, 1'b0, int'($urandom_range(0, 3)), B + 3, ref_mem[idx], 1'b0, "rnd_rd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
